led_pattern_sequencer: RTL
==========================

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter LED_W, default 10, LED port width.
REQ-002 SHALL have parameter DEPTH, default 8, pattern entries (power of two).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  4  CSR slave word address.
REQ-006 SHALL have port chipselect  input  1  CSR slave select.
REQ-007 SHALL have port write_n  input  1  CSR slave write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  CSR slave write data.
REQ-009 SHALL have port readdata  output  32  CSR slave read data, combinational from address, zero wait states.
REQ-010 SHALL have ports m_address  output  2; m_chipselect  output  1; m_write_n  output  1; m_writedata  output  32.
- Avalon-MM master toward the LED PIO.
REQ-011 SHALL have port m_waitrequest  input  1  master stall.

Function
REQ-012 SHALL decode CSR map:
- 0 CTRL: bit0 enable, bit1 oneshot, R/W.
- 1 PERIOD: bits23:0 clocks per step, R/W.
- 2 LENGTH: bits2:0 last step index, R/W.
- 3 STATUS: RO; bit0 busy, bits6:4 current index.
- 8..15 PATTERN[0..7]: bits LED_W-1:0, R/W.
- Unused addresses and bits read 0; writes to them ignored.
REQ-013 SHALL use FSM states IDLE, WRITE, WAIT.
REQ-014 IDLE->WRITE when enable=1; index loaded 0.
REQ-015 WRITE SHALL drive m_chipselect=1, m_write_n=0, m_address=0, m_writedata={zero-pad, PATTERN[index]}.
- Values held stable while m_waitrequest=1.
- Write completes on the first cycle m_waitrequest=0; next state WAIT, counter loaded PERIOD-1.
REQ-016 WAIT SHALL decrement counter once per clock.
- At counter=0 with index!=LENGTH: index+1, go WRITE.
- At counter=0 with index=LENGTH, oneshot=0: index wraps to 0, go WRITE.
- At counter=0 with index=LENGTH, oneshot=1: enable cleared, go IDLE.
REQ-017 PERIOD=0 SHALL behave as PERIOD=1: one WAIT cycle, a write every 2 clocks minimum with no stall.
REQ-018 Master outputs outside WRITE SHALL be m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
REQ-019 Enable cleared by CSR during WAIT SHALL force IDLE next cycle.
- Cleared during WRITE: the pending write completes first, then IDLE; a write is never aborted.
REQ-020 PATTERN, PERIOD and LENGTH writes while running SHALL take effect at the next WRITE fetch or counter load, never mid-step.
REQ-021 LENGTH write below current index SHALL take effect at step end: index=LENGTH counts as wrap, index>LENGTH also wraps to 0.
REQ-022 CSR write to CTRL coinciding with oneshot auto-clear: the CSR write value SHALL win.
REQ-023 busy SHALL be 1 in WRITE and WAIT, 0 in IDLE.

Reset
REQ-024 Reset assertion SHALL asynchronously force IDLE, index=0, counter=0 and all CSRs to 0.
- Master outputs take REQ-018 values; readdata=0 at address 0.
REQ-025 Reset mid-WRITE SHALL abandon the transfer immediately.
- LED PIO keeps its own reset value.

Structure
REQ-026 CSR address constants, CTRL bit positions and the FSM state enum SHALL live in shared package led_seq_pkg.
REQ-027 Pattern storage SHALL be flops (DEPTH x LED_W) inside sub-module led_pattern_regfile (write port plus two async read ports: CSR and sequencer).

Verification
REQ-028 PATTERN0..2=0x001,0x002,0x004, LENGTH=2, PERIOD=3, CTRL=1, no stall
- Master writes 0x001,0x002,0x004,0x001...
- Write starts spaced 4 clocks apart.
REQ-029 Same setup with CTRL=3
- Exactly three writes, then busy=0 and CTRL reads 0x2.
REQ-030 m_waitrequest=1 for 5 cycles on the second write
- m_writedata=0x002 held all 5 cycles.
- Next write starts PERIOD+1 clocks after completion.
REQ-031 CTRL=0 written during stalled WRITE
- Write completes once, then IDLE, no further writes.
REQ-032 PERIOD=0, LENGTH=0, PATTERN0=0x3FF, CTRL=1
- 0x3FF written every 2 clocks.
REQ-033 reset_n low mid-WAIT
- Same cycle: busy=0, CSRs read 0, m_chipselect=0.
- After release, no writes until CTRL=1.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: CSR map, CTRL bit positions
// and the sequencer state encoding.
package led_seq_pkg;

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_PERIOD   = 4'd1;
  localparam logic [3:0] ADDR_LENGTH   = 4'd2;
  localparam logic [3:0] ADDR_STATUS   = 4'd3;
  localparam logic [3:0] ADDR_PAT_BASE = 4'd8;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Avalon-MM style buses of the sequencer: CSR slave port and LED PIO master port.
// Handshake: a CSR write is accepted in any cycle with chipselect=1 and write_n=0 (zero
// wait states); a master write holds its values until the first cycle m_waitrequest=0.
interface led_seq_csr_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

interface led_seq_avm_if;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  modport master (output m_address, m_chipselect, m_write_n, m_writedata, input m_waitrequest);
  modport slave  (input m_address, m_chipselect, m_write_n, m_writedata, output m_waitrequest);
endinterface

// File: rtl/led_pattern_regfile.sv
// Flop-based pattern store: one write port, one read port for CSR readback and
// one for the sequencer fetch.
module led_pattern_regfile #(
  parameter int LED_W = 10,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [LED_W-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_a_i,
  output logic [LED_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0] raddr_b_i,
  output logic [LED_W-1:0] rdata_b_o
);
  logic [LED_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps through a CSR-programmed table of LED patterns, writing one entry to the LED
// PIO per step over an Avalon-MM master, with a programmable number of clocks per step.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W = 10,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  led_seq_csr_if.slave  csr,
  led_seq_avm_if.master avm,
  output seq_state_e    dbg_state_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seq_state_e       state_q;
  logic [IDX_W-1:0] index_q, fetch_idx, length_q, csr_pat_idx;
  logic [23:0]      count_q, period_q;
  logic [1:0]       ctrl_q, ctrl_eff;
  logic             m_cs_q, m_wn_q;
  logic [LED_W-1:0] m_wd_q, csr_pat_rd, seq_pat_rd;
  logic             csr_wr, ctrl_wr, pat_hit, busy;
  logic             unused_wdata;

  assign csr_wr      = csr.chipselect && !csr.write_n;
  assign ctrl_wr     = csr_wr && (csr.address == ADDR_CTRL);
  assign pat_hit     = (csr.address >= ADDR_PAT_BASE) && (int'(csr.address[2:0]) < DEPTH);
  assign csr_pat_idx = IDX_W'(csr.address[2:0]);
  // A CTRL write in the same cycle overrides both the stored value and any auto-clear.
  assign ctrl_eff    = ctrl_wr ? csr.writedata[1:0] : ctrl_q;
  assign busy        = (state_q != ST_IDLE);
  assign unused_wdata = ^csr.writedata[31:24];

  led_pattern_regfile #(.LED_W(LED_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_regfile (
    .clk       (clk),
    .rst_n     (reset_n),
    .we_i      (csr_wr && pat_hit),
    .waddr_i   (csr_pat_idx),
    .wdata_i   (csr.writedata[LED_W-1:0]),
    .raddr_a_i (csr_pat_idx),
    .rdata_a_o (csr_pat_rd),
    .raddr_b_i (fetch_idx),
    .rdata_b_o (seq_pat_rd)
  );

  // Index of the entry fetched on the next entry into WRITE; anything at or past LENGTH wraps.
  always_comb begin
    fetch_idx = '0;
    if (state_q == ST_WAIT && index_q < length_q) fetch_idx = index_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      length_q <= '0;
    end else if (csr_wr) begin
      if (csr.address == ADDR_PERIOD) period_q <= csr.writedata[23:0];
      if (csr.address == ADDR_LENGTH) length_q <= csr.writedata[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      count_q <= '0;
      ctrl_q  <= '0;
      m_cs_q  <= 1'b0;
      m_wn_q  <= 1'b1;
      m_wd_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_q[CTRL_EN_BIT]) begin
            state_q <= ST_WRITE;
            index_q <= '0;
            m_cs_q  <= 1'b1;
            m_wn_q  <= 1'b0;
            m_wd_q  <= seq_pat_rd;
          end
        end
        ST_WRITE: begin
          if (!avm.m_waitrequest) begin
            m_cs_q <= 1'b0;
            m_wn_q <= 1'b1;
            m_wd_q <= '0;
            if (ctrl_eff[CTRL_EN_BIT]) begin
              state_q <= ST_WAIT;
              count_q <= (period_q == '0) ? '0 : period_q - 24'd1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_WAIT: begin
          if (!ctrl_eff[CTRL_EN_BIT]) begin
            state_q <= ST_IDLE;
          end else if (count_q != '0) begin
            count_q <= count_q - 24'd1;
          end else if (index_q >= length_q && ctrl_eff[CTRL_ONESHOT_BIT]) begin
            state_q <= ST_IDLE;
            ctrl_q[CTRL_EN_BIT] <= 1'b0;
          end else begin
            state_q <= ST_WRITE;
            index_q <= fetch_idx;
            m_cs_q  <= 1'b1;
            m_wn_q  <= 1'b0;
            m_wd_q  <= seq_pat_rd;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (ctrl_wr) ctrl_q <= csr.writedata[1:0];
    end
  end

  always_comb begin
    csr.readdata = '0;
    case (csr.address)
      ADDR_CTRL:   csr.readdata = 32'(ctrl_q);
      ADDR_PERIOD: csr.readdata = 32'(period_q);
      ADDR_LENGTH: csr.readdata = 32'(length_q);
      ADDR_STATUS: csr.readdata = 32'({index_q, 3'b000, busy});
      default:     if (pat_hit) csr.readdata = 32'(csr_pat_rd);
    endcase
  end

  assign avm.m_address    = 2'b00;
  assign avm.m_chipselect = m_cs_q;
  assign avm.m_write_n    = m_wn_q;
  assign avm.m_writedata  = 32'(m_wd_q);
  assign dbg_state_o      = state_q;
endmodule
